// File: rtl/coder_n_onehot_pipe_if.sv
// ---------------------------------------------------------------------------
// coder_n_onehot_pipe_if
//   Handshake bundle for coder_n_onehot_pipe: index producer side (in_*)
//   and decoded-code consumer side (out_*, result).
//   Optional macro CODER_THERMO_MODE_EN adds the per-entry 'mode' bit.
//   master: the environment (drives index / out_ready).
//   slave : the decoder block.
// ---------------------------------------------------------------------------
interface coder_n_onehot_pipe_if #(
    parameter int IDX_W = 2
) ();
    localparam int OUT_W = 2 ** IDX_W;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] index;
`ifdef CODER_THERMO_MODE_EN
    logic             mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;

`ifdef CODER_THERMO_MODE_EN
    modport master (
        output in_valid, index, mode, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, index, mode, out_ready,
        output in_ready, out_valid, result
    );
`else
    modport master (
        output in_valid, index, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, index, out_ready,
        output in_ready, out_valid, result
    );
`endif
endinterface

// File: rtl/coder_n_onehot_pipe.sv
// ---------------------------------------------------------------------------
// coder_n_onehot_pipe
//   Registered IDX_W-to-2**IDX_W one-hot decoder with valid/ready on both
//   sides. A main register drives 'result'; a skid register absorbs one
//   extra code so the producer sees full throughput under backpressure.
//   dec_count counts delivered codes and saturates at all-ones.
//   Optional macro: CODER_THERMO_MODE_EN -- adds a 'mode' input in the
//   interface; mode=1 selects a thermometer code (result[i] = i <= index).
//   The mode bit is folded into the stored code, so each buffered entry
//   keeps the mode it was accepted with.
// ---------------------------------------------------------------------------
module coder_n_onehot_pipe #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    coder_n_onehot_pipe_if.slave  bus,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      dec_count
);
    localparam int OUT_W = 2 ** IDX_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] main_q,  main_d;
    logic [OUT_W-1:0] skid_q,  skid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             out_valid_s;
    logic             in_ready_s;
    logic             in_fire;
    logic             out_fire;
    logic [OUT_W-1:0] in_code;

    // Decode one index into its output code (one-hot, or thermometer when
    // the optional mode bit requests it).
`ifdef CODER_THERMO_MODE_EN
    function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] idx,
                                                input logic             thermo);
        logic [OUT_W-1:0] code;
        for (int i = 0; i < OUT_W; i++) begin
            code[i] = thermo ? (IDX_W'(i) <= idx) : (IDX_W'(i) == idx);
        end
        return code;
    endfunction

    assign in_code = decode(bus.index, bus.mode);
`else
    function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [OUT_W-1:0] code;
        for (int i = 0; i < OUT_W; i++) begin
            code[i] = (IDX_W'(i) == idx);
        end
        return code;
    endfunction

    assign in_code = decode(bus.index);
`endif

    assign in_fire  = bus.in_valid  & in_ready_s;
    assign out_fire = out_valid_s   & bus.out_ready;

    // State register: FSM state plus the two code buffers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its neighbours; blocking here would create
    // order-dependent shift-through between main_q and skid_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both buffers are small registers (not RAM), so they are
            // reset explicitly; this makes result=0 right after reset and
            // guarantees a mid-transfer reset discards any buffered code.
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state logic: FIFO-ordered two-entry buffer. The head always
    // lives in main_q; the skid entry only exists in state TWO.
    always_comb begin
        // NOTE: every comb output gets a default first, so no branch can
        // leave a variable unassigned and infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_code;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d  = in_code;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_code;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output decode: handshake flags come from the state register only, so
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        out_valid_s = (state_q != EMPTY);
        in_ready_s  = (state_q != TWO);
    end

    assign bus.out_valid = out_valid_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.result    = main_q;

    // Delivered-code counter next value: clear has priority, then a
    // saturating increment on each delivery.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Delivered-code counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dec_count = cnt_q;

endmodule

// File: tb/tb_coder_n_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_coder_n_onehot_pipe
//   Three instances: u2 (IDX_W=2, CNT_W=4) for directed tables, saturation
//   and reset cases; u3 (IDX_W=3, CNT_W=8) for random traffic against a
//   queue-based model; u1 (IDX_W=1) for the 2-bit edge case.
//   Honours CODER_THERMO_MODE_EN (adds the thermometer table and random mode).
// ---------------------------------------------------------------------------
module tb_coder_n_onehot_pipe;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    coder_n_onehot_pipe_if #(.IDX_W(2)) b2 ();
    coder_n_onehot_pipe_if #(.IDX_W(3)) b3 ();
    coder_n_onehot_pipe_if #(.IDX_W(1)) b1 ();

    logic       clr2, clr3, clr1;
    logic [3:0] cnt2;
    logic [7:0] cnt3;
    logic [7:0] cnt1;

    coder_n_onehot_pipe #(.IDX_W(2), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2), .cnt_clr(clr2), .dec_count(cnt2));
    coder_n_onehot_pipe #(.IDX_W(3), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .cnt_clr(clr3), .dec_count(cnt3));
    coder_n_onehot_pipe #(.IDX_W(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .cnt_clr(clr1), .dec_count(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] idx;
        logic       md;
        logic       ordy;
        logic       clr;
        logic       e_ov;
        logic       e_ir;
        logic [3:0] e_res;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic iv, input logic [1:0] idx, input logic md,
                          input logic ordy, input logic clr);
        b2.in_valid  = iv;
        b2.index     = idx;
        b2.out_ready = ordy;
        clr2         = clr;
`ifdef CODER_THERMO_MODE_EN
        b2.mode      = md;
`else
        if (md) $display("note: mode ignored in one-hot build");
`endif
    endtask

    function automatic vec_t mk(input logic iv, input logic [1:0] idx, input logic md,
                                input logic ordy, input logic clr, input logic e_ov,
                                input logic e_ir, input logic [3:0] e_res,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.iv = iv; v.idx = idx; v.md = md; v.ordy = ordy; v.clr = clr;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_res = e_res; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Reference code from the rules: one-hot = 1<<idx, thermometer = 2^(idx+1)-1.
    function automatic int ref_code(input int idx, input int md);
        return md ? ((1 << (idx + 1)) - 1) : (1 << idx);
    endfunction

    initial begin
        int q3[$];
        int hold3;
        int mcnt3;
        rst_n = 1'b0;
        drive2(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);   // in_valid high during reset: must be ignored
        b3.in_valid = 1'b0; b3.index = '0; b3.out_ready = 1'b0; clr3 = 1'b0;
        b1.in_valid = 1'b0; b1.index = '0; b1.out_ready = 1'b0; clr1 = 1'b0;
`ifdef CODER_THERMO_MODE_EN
        b3.mode = 1'b0; b1.mode = 1'b0;
`endif

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst u2 out_valid", b2.out_valid, 1'b0);
        check("rst u2 in_ready",  b2.in_ready,  1'b1);
        check("rst u2 result",    b2.result,    4'h0);
        check("rst u2 dec_count", cnt2,         4'h0);
        check("rst u3 out_valid", b3.out_valid, 1'b0);
        check("rst u1 out_valid", b1.out_valid, 1'b0);
        drive2(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post-rst u2 out_valid", b2.out_valid, 1'b0);

        // ---------------- directed tables ----------------
        // Expectations are the outputs just after the edge that applies the row.
        tbl.push_back(mk(1, 2'd0, 0, 1, 0, 1, 1, 4'b0001, 4'd0));
        tbl.push_back(mk(1, 2'd1, 0, 1, 0, 1, 1, 4'b0010, 4'd1));
        tbl.push_back(mk(1, 2'd2, 0, 1, 0, 1, 1, 4'b0100, 4'd2));
        tbl.push_back(mk(1, 2'd3, 0, 1, 0, 1, 1, 4'b1000, 4'd3));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 0, 1, 4'b1000, 4'd4));
        tbl.push_back(mk(1, 2'd1, 0, 0, 0, 1, 1, 4'b0010, 4'd4));
        tbl.push_back(mk(1, 2'd3, 0, 0, 0, 1, 0, 4'b0010, 4'd4));
        tbl.push_back(mk(1, 2'd0, 0, 0, 0, 1, 0, 4'b0010, 4'd4));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 1, 1, 4'b1000, 4'd5));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 0, 1, 4'b1000, 4'd6));
        tbl.push_back(mk(1, 2'd2, 0, 0, 0, 1, 1, 4'b0100, 4'd6));
        tbl.push_back(mk(0, 2'd0, 0, 1, 1, 0, 1, 4'b0100, 4'd0));
`ifdef CODER_THERMO_MODE_EN
        tbl.push_back(mk(1, 2'd0, 1, 1, 0, 1, 1, 4'b0001, 4'd0));
        tbl.push_back(mk(1, 2'd2, 1, 1, 0, 1, 1, 4'b0111, 4'd1));
        tbl.push_back(mk(1, 2'd3, 1, 1, 0, 1, 1, 4'b1111, 4'd2));
        tbl.push_back(mk(1, 2'd2, 0, 0, 0, 1, 0, 4'b1111, 4'd2));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 1, 1, 4'b0100, 4'd3));
        tbl.push_back(mk(1, 2'd1, 1, 0, 0, 1, 0, 4'b0100, 4'd3));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 1, 1, 4'b0011, 4'd4));
        tbl.push_back(mk(0, 2'd0, 0, 1, 0, 0, 1, 4'b0011, 4'd5));
`endif
        for (int r = 0; r < tbl.size(); r++) begin
            drive2(tbl[r].iv, tbl[r].idx, tbl[r].md, tbl[r].ordy, tbl[r].clr);
            tick();
            check($sformatf("tbl[%0d] out_valid", r), b2.out_valid, tbl[r].e_ov);
            check($sformatf("tbl[%0d] in_ready",  r), b2.in_ready,  tbl[r].e_ir);
            check($sformatf("tbl[%0d] result",    r), b2.result,    tbl[r].e_res);
            check($sformatf("tbl[%0d] dec_count", r), cnt2,         tbl[r].e_cnt);
        end

        // ---------------- counter saturation (CNT_W=4) ----------------
        drive2(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("sat clr", cnt2, 4'd0);
        for (int k = 0; k < 20; k++) begin
            drive2(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive2(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sat dec_count after 20", cnt2, 4'd15);
        check("sat drained", b2.out_valid, 1'b0);
        drive2(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        drive2(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);   // clear on the delivery cycle
        tick();
        check("clr beats fire dec_count", cnt2, 4'd0);
        check("clr beats fire delivered",  b2.out_valid, 1'b0);

        // ---------------- async reset while in TWO ----------------
        drive2(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive2(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        drive2(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check("pre-rst TWO in_ready",  b2.in_ready, 1'b0);
        check("pre-rst TWO result",    b2.result,   4'b0010);
        check("pre-rst TWO dec_count", cnt2,        4'd1);
        drive2(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", b2.out_valid, 1'b0);
        check("async rst in_ready",  b2.in_ready,  1'b1);
        check("async rst result",    b2.result,    4'h0);
        check("async rst dec_count", cnt2,         4'd0);
        tick();
        check("in rst ignores in_valid", b2.out_valid, 1'b0);
        drive2(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post-rst idle 1", b2.out_valid, 1'b0);
        tick();
        check("post-rst idle 2", b2.out_valid, 1'b0);
        drive2(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("post-rst push valid",  b2.out_valid, 1'b1);
        check("post-rst push result", b2.result,    4'b0100);
        drive2(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check("post-rst drain", b2.out_valid, 1'b0);

        // ---------------- IDX_W=1 edge case ----------------
        b1.in_valid = 1'b1; b1.index = 1'b0; b1.out_ready = 1'b1;
        tick();
        check("idx1 index0 result", b1.result, 2'b01);
        b1.index = 1'b1;
        tick();
        check("idx1 index1 result", b1.result, 2'b10);
        check("idx1 index1 valid",  b1.out_valid, 1'b1);
        b1.in_valid = 1'b0;
        tick();
        check("idx1 drained",   b1.out_valid, 1'b0);
        check("idx1 dec_count", cnt1, 8'd2);

        // ---------------- random traffic on u3 vs model ----------------
        hold3 = 0;
        mcnt3 = 0;
        for (int c = 0; c < 10000; c++) begin
            int  e_ov, e_ir, e_res, idx, md;
            logic iv, ordy, clr, ifire, ofire;
            e_ov  = (q3.size() > 0) ? 1 : 0;
            e_ir  = (q3.size() < 2) ? 1 : 0;
            e_res = (q3.size() > 0) ? q3[0] : hold3;
            check("rnd out_valid", {63'd0, b3.out_valid}, 64'(e_ov));
            check("rnd in_ready",  {63'd0, b3.in_ready},  64'(e_ir));
            check("rnd result",    {56'd0, b3.result},    64'(e_res));
            check("rnd dec_count", {56'd0, cnt3},         64'(mcnt3));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            clr  = ($urandom_range(0, 299) == 0);
            idx  = int'($urandom_range(0, 7));
`ifdef CODER_THERMO_MODE_EN
            md   = int'($urandom_range(0, 1));
            b3.mode = md[0];
`else
            md   = 0;
`endif
            b3.in_valid = iv; b3.index = 3'(idx); b3.out_ready = ordy; clr3 = clr;
            ifire = iv && (e_ir != 0);
            ofire = ordy && (e_ov != 0);
            tick();
            if (ofire) hold3 = q3.pop_front();
            if (ifire) q3.push_back(ref_code(idx, md));
            if (clr)                         mcnt3 = 0;
            else if (ofire && mcnt3 < 255)   mcnt3 = mcnt3 + 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
